// File: rtl/core_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: FSM states, trap causes,
// major opcodes and branch funct3 codes.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_EXECUTE   = 3'd1,
    ST_MEM_REQ   = 3'd2,
    ST_MEM_WAIT  = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_t;

  localparam logic [2:0] TRAP_NONE      = 3'd0;
  localparam logic [2:0] TRAP_ILLEGAL   = 3'd1;
  localparam logic [2:0] TRAP_FETCH_MIS = 3'd2;
  localparam logic [2:0] TRAP_DATA_MIS  = 3'd3;
  localparam logic [2:0] TRAP_TIMEOUT   = 3'd4;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic is_rv32i_opcode(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_MISC_MEM, OP_OP_IMM, OP_AUIPC, OP_STORE, OP_OP,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/next_pc_select.sv
// PC-select mux: sequential, branch-target and jump-target selection.
// Branch compares come from the ALU (zero flag or the set-less-than bit).
module next_pc_select
  import core_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic        is_jal_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  output logic [31:0] next_pc_o
);

  logic taken;
  logic [31:0] pc_plus_imm, pc_plus_4;

  assign pc_plus_imm = pc_i + imm_i;
  assign pc_plus_4   = pc_i + 32'd4;

  always_comb begin
    taken = 1'b0;
    case (funct3_i)
      F3_BEQ:           taken = alu_zero_i;
      F3_BNE:           taken = !alu_zero_i;
      F3_BLT, F3_BLTU:  taken = alu_result_i[0];
      F3_BGE, F3_BGEU:  taken = !alu_result_i[0];
      default:          taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc_o = pc_plus_4;
    if (jump_i)
      next_pc_o = is_jal_i ? pc_plus_imm : {alu_result_i[31:1], 1'b0};
    else if (branch_i && taken)
      next_pc_o = pc_plus_imm;
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: fetch, execute, data access, writeback, sticky trap.
// Owns the handshake timeout counter and the retired-instruction counter.
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 pll_1_200MHz,
  input  logic                 pll_1_locked_synced,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 branch,
  input  logic                 jump,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 reg_write,
  input  logic [31:0]          current_pc_address,
  input  logic [31:0]          immediate_value,
  input  logic [31:0]          alu_result,
  input  logic                 alu_zero_flag,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 dmem_rvalid,
  output logic                 imem_req,
  output logic                 instr_latch_enable,
  output logic                 dmem_req,
  output logic                 dmem_write,
  output logic                 load_latch_enable,
  output logic                 reg_write_enable,
  output logic                 pc_write_enable,
  output logic [31:0]          next_pc_address,
  output logic                 halted,
  output logic [2:0]           trap_cause,
  output logic [CNT_WIDTH-1:0] instret_count
);

  state_t state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [2:0]  cause_q, cause_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic ireq_c, ilatch_c, dreq_c, dwr_c, llatch_c, rwe_c, pwe_c;
  logic tmo_hit, waiting, illegal, data_mis, mem_op;

  next_pc_select u_npc (
    .funct3_i     (funct3),
    .branch_i     (branch),
    .jump_i       (jump),
    .is_jal_i     (opcode[3]),
    .pc_i         (current_pc_address),
    .imm_i        (immediate_value),
    .alu_result_i (alu_result),
    .alu_zero_i   (alu_zero_flag),
    .next_pc_o    (next_pc_address)
  );

  assign mem_op   = mem_read | mem_write;
  assign illegal  = (mem_read & mem_write) | !is_rv32i_opcode(opcode) |
                    (branch & (funct3 == 3'b010 || funct3 == 3'b011));
  assign data_mis = mem_op & (((funct3[1:0] == 2'b10) & (alu_result[1:0] != 2'b00)) |
                              ((funct3[1:0] == 2'b01) & alu_result[0]));
  assign tmo_hit  = (tmo_q == 16'(MEM_TIMEOUT - 1));
  assign waiting  = (state_q == ST_FETCH) || (state_q == ST_MEM_REQ) || (state_q == ST_MEM_WAIT);

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    ireq_c = 1'b0; ilatch_c = 1'b0; dreq_c = 1'b0; dwr_c = 1'b0;
    llatch_c = 1'b0; rwe_c = 1'b0; pwe_c = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ireq_c = 1'b1;
        if (imem_ready) begin
          ilatch_c = 1'b1;
          state_d  = ST_EXECUTE;
        end else if (tmo_hit) begin
          state_d = ST_TRAP; cause_d = TRAP_TIMEOUT;
        end
      end
      ST_EXECUTE: begin
        if (illegal) begin
          state_d = ST_TRAP; cause_d = TRAP_ILLEGAL;
        end else if (next_pc_address[1:0] != 2'b00) begin
          state_d = ST_TRAP; cause_d = TRAP_FETCH_MIS;
        end else if (data_mis) begin
          state_d = ST_TRAP; cause_d = TRAP_DATA_MIS;
        end else begin
          state_d = mem_op ? ST_MEM_REQ : ST_WRITEBACK;
        end
      end
      ST_MEM_REQ: begin
        dreq_c = 1'b1;
        dwr_c  = mem_write;
        if (dmem_ready)
          state_d = mem_write ? ST_WRITEBACK : ST_MEM_WAIT;
        else if (tmo_hit) begin
          state_d = ST_TRAP; cause_d = TRAP_TIMEOUT;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_rvalid) begin
          llatch_c = 1'b1;
          state_d  = ST_WRITEBACK;
        end else if (tmo_hit) begin
          state_d = ST_TRAP; cause_d = TRAP_TIMEOUT;
        end
      end
      ST_WRITEBACK: begin
        rwe_c     = reg_write;
        pwe_c     = 1'b1;
        instret_d = instret_q + CNT_WIDTH'(1);
        state_d   = ST_FETCH;
      end
      default: state_d = ST_TRAP;
    endcase
    // Counter restarts on every state change so each handshake gets a full budget.
    tmo_d = (state_d != state_q || !waiting) ? 16'd0 : tmo_q + 16'd1;
  end

  always_ff @(posedge pll_1_200MHz or negedge pll_1_locked_synced) begin
    if (!pll_1_locked_synced) begin
      state_q   <= ST_FETCH;
      tmo_q     <= 16'd0;
      cause_q   <= TRAP_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Reset gates the state-decoded strobes so a request drops the instant reset asserts.
  assign imem_req           = ireq_c   & pll_1_locked_synced;
  assign instr_latch_enable = ilatch_c & pll_1_locked_synced;
  assign dmem_req           = dreq_c   & pll_1_locked_synced;
  assign dmem_write         = dwr_c    & pll_1_locked_synced;
  assign load_latch_enable  = llatch_c & pll_1_locked_synced;
  assign reg_write_enable   = rwe_c    & pll_1_locked_synced;
  assign pc_write_enable    = pwe_c    & pll_1_locked_synced;
  assign halted             = (state_q == ST_TRAP);
  assign trap_cause         = cause_q;
  assign instret_count      = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: instruction scenarios with hand-computed strobes,
// next-PC values, trap causes and retire counts.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        branch = 0, jump = 0, mem_read = 0, mem_write = 0, reg_write = 0;
  logic [31:0] pc = '0, imm = '0, alu = '0;
  logic        zero = 0, imem_ready = 0, dmem_ready = 0, dmem_rvalid = 0;
  logic        imem_req, instr_latch_enable, dmem_req, dmem_write, load_latch_enable;
  logic        reg_write_enable, pc_write_enable, halted;
  logic [31:0] next_pc_address;
  logic [2:0]  trap_cause;
  logic [31:0] instret_count;

  int checks = 0;
  int failures = 0;
  int exp_instret = 0;

  always #5 clk = ~clk;

  core_sequencer #(.MEM_TIMEOUT(4), .CNT_WIDTH(32)) dut (
    .pll_1_200MHz        (clk),
    .pll_1_locked_synced (rst_n),
    .opcode              (opcode),
    .funct3              (funct3),
    .branch              (branch),
    .jump                (jump),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .reg_write           (reg_write),
    .current_pc_address  (pc),
    .immediate_value     (imm),
    .alu_result          (alu),
    .alu_zero_flag       (zero),
    .imem_ready          (imem_ready),
    .dmem_ready          (dmem_ready),
    .dmem_rvalid         (dmem_rvalid),
    .imem_req            (imem_req),
    .instr_latch_enable  (instr_latch_enable),
    .dmem_req            (dmem_req),
    .dmem_write          (dmem_write),
    .load_latch_enable   (load_latch_enable),
    .reg_write_enable    (reg_write_enable),
    .pc_write_enable     (pc_write_enable),
    .next_pc_address     (next_pc_address),
    .halted              (halted),
    .trap_cause          (trap_cause),
    .instret_count       (instret_count)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic br, input logic jp, input logic mr,
                           input logic mw, input logic rw, input logic [31:0] p,
                           input logic [31:0] im, input logic [31:0] a, input logic z);
    opcode = op; funct3 = f3; branch = br; jump = jp; mem_read = mr;
    mem_write = mw; reg_write = rw; pc = p; imm = im; alu = a; zero = z;
  endtask

  // Hold reset for one edge, release just after the edge; state is FETCH afterwards.
  task automatic do_reset();
    rst_n = 1'b0; imem_ready = 0; dmem_ready = 0; dmem_rvalid = 0;
    tick();
    rst_n = 1'b1; exp_instret = 0;
  endtask

  task automatic test_reset();
    set_instr(7'b0010011, 3'b000, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0);
    rst_n = 1'b0; imem_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req act=%b exp=0", imem_req); end
    checks++; if (instr_latch_enable !== 1'b0) begin failures++; $display("FAIL reset_latch act=%b exp=0", instr_latch_enable); end
    checks++; if ({dmem_req, load_latch_enable, reg_write_enable, pc_write_enable} !== 4'b0) begin
      failures++; $display("FAIL reset_strobes act=%b exp=0000", {dmem_req, load_latch_enable, reg_write_enable, pc_write_enable}); end
    checks++; if (halted !== 1'b0 || trap_cause !== 3'd0) begin
      failures++; $display("FAIL reset_trap act=%b/%0d exp=0/0", halted, trap_cause); end
    checks++; if (instret_count !== 32'd0) begin failures++; $display("FAIL reset_instret act=%0d exp=0", instret_count); end
    tick(); tick();
    imem_ready = 1'b0; rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_fetch_resume act=%b exp=1", imem_req); end
  endtask

  task automatic test_addi();
    int rwe_cnt = 0;
    set_instr(7'b0010011, 3'b000, 0, 0, 0, 0, 1, 32'h0, 32'h5, 32'h5, 0);
    for (int c = 0; c < 3; c++) begin
      imem_ready = (c == 2); #1;
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL addi_imem_req c=%0d act=%b exp=1", c, imem_req); end
      checks++; if (instr_latch_enable !== 1'(c == 2)) begin
        failures++; $display("FAIL addi_latch c=%0d act=%b exp=%b", c, instr_latch_enable, c == 2); end
      rwe_cnt += int'(reg_write_enable);
      tick();
    end
    imem_ready = 1'b0; #1;
    checks++; if (imem_req !== 1'b0 || pc_write_enable !== 1'b0) begin
      failures++; $display("FAIL addi_exec_strobes act=%b%b exp=00", imem_req, pc_write_enable); end
    rwe_cnt += int'(reg_write_enable);
    tick(); #1;
    checks++; if (pc_write_enable !== 1'b1 || next_pc_address !== 32'h4) begin
      failures++; $display("FAIL addi_wb act=%b/%h exp=1/00000004", pc_write_enable, next_pc_address); end
    rwe_cnt += int'(reg_write_enable);
    exp_instret++;
    tick(); #1;
    rwe_cnt += int'(reg_write_enable);
    checks++; if (rwe_cnt != 1) begin failures++; $display("FAIL addi_rwe_count act=%0d exp=1", rwe_cnt); end
    checks++; if (instret_count !== 32'(exp_instret) || imem_req !== 1'b1) begin
      failures++; $display("FAIL addi_instret act=%0d/%b exp=%0d/1", instret_count, imem_req, exp_instret); end
  endtask

  task automatic test_branch();
    logic [2:0]  f3s [6] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b101, 3'b111};
    logic        zs  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] as  [6] = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h1, 32'h0};
    logic [31:0] exp [6] = '{32'h120, 32'h104, 32'h120, 32'h120, 32'h104, 32'h120};
    for (int i = 0; i < 6; i++) begin
      set_instr(7'b1100011, f3s[i], 1, 0, 0, 0, 0, 32'h100, 32'h20, as[i], zs[i]);
      imem_ready = 1'b1; #1;
      tick();
      imem_ready = 1'b0; #1;
      checks++; if (next_pc_address !== exp[i]) begin
        failures++; $display("FAIL branch_exec_npc i=%0d act=%h exp=%h", i, next_pc_address, exp[i]); end
      tick(); #1;
      checks++; if (pc_write_enable !== 1'b1 || reg_write_enable !== 1'b0 || next_pc_address !== exp[i]) begin
        failures++; $display("FAIL branch_wb i=%0d act=%b%b/%h exp=10/%h", i, pc_write_enable, reg_write_enable, next_pc_address, exp[i]); end
      exp_instret++;
      tick();
    end
    #1;
    checks++; if (instret_count !== 32'(exp_instret)) begin
      failures++; $display("FAIL branch_instret act=%0d exp=%0d", instret_count, exp_instret); end
  endtask

  task automatic test_jal();
    logic [31:0] pcs [2] = '{32'h200, 32'hFFFF_FFF0};
    logic [31:0] ims [2] = '{32'h10, 32'h20};
    logic [31:0] exp [2] = '{32'h210, 32'h10};
    for (int i = 0; i < 2; i++) begin
      set_instr(7'b1101111, 3'b000, 0, 1, 0, 0, 1, pcs[i], ims[i], 32'h0, 0);
      imem_ready = 1'b1; #1;
      tick();
      imem_ready = 1'b0;
      tick(); #1;
      checks++; if (reg_write_enable !== 1'b1 || pc_write_enable !== 1'b1 || next_pc_address !== exp[i]) begin
        failures++; $display("FAIL jal_wb i=%0d act=%b%b/%h exp=11/%h", i, reg_write_enable, pc_write_enable, next_pc_address, exp[i]); end
      exp_instret++;
      tick();
    end
  endtask

  task automatic test_load_store();
    int lle_cnt = 0, rwe_cnt = 0;
    set_instr(7'b0000011, 3'b010, 0, 0, 1, 0, 1, 32'h300, 32'h0, 32'h1000, 0);
    imem_ready = 1'b1; #1;
    tick();
    imem_ready = 1'b0; #1;
    checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL lw_exec_req act=%b exp=0", dmem_req); end
    tick();
    for (int c = 1; c <= 5; c++) begin
      dmem_ready = (c == 3); dmem_rvalid = (c == 1 || c == 5); #1;
      checks++; if (dmem_req !== 1'(c <= 3) || dmem_write !== 1'b0) begin
        failures++; $display("FAIL lw_req c=%0d act=%b%b exp=%b0", c, dmem_req, dmem_write, c <= 3); end
      lle_cnt += int'(load_latch_enable); rwe_cnt += int'(reg_write_enable);
      tick();
    end
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; #1;
    checks++; if (reg_write_enable !== 1'b1 || next_pc_address !== 32'h304) begin
      failures++; $display("FAIL lw_wb act=%b/%h exp=1/00000304", reg_write_enable, next_pc_address); end
    lle_cnt += int'(load_latch_enable); rwe_cnt += int'(reg_write_enable);
    exp_instret++;
    tick();
    checks++; if (lle_cnt != 1 || rwe_cnt != 1) begin
      failures++; $display("FAIL lw_strobe_counts act=%0d/%0d exp=1/1", lle_cnt, rwe_cnt); end
    // Aligned store: no MEM_WAIT, straight to writeback after the accept.
    set_instr(7'b0100011, 3'b010, 0, 0, 0, 1, 0, 32'h304, 32'h0, 32'h2000, 0);
    imem_ready = 1'b1; #1;
    tick();
    imem_ready = 1'b0;
    tick();
    dmem_ready = 1'b1; #1;
    checks++; if (dmem_req !== 1'b1 || dmem_write !== 1'b1) begin
      failures++; $display("FAIL sw_req act=%b%b exp=11", dmem_req, dmem_write); end
    tick();
    dmem_ready = 1'b0; #1;
    checks++; if (pc_write_enable !== 1'b1 || reg_write_enable !== 1'b0 || next_pc_address !== 32'h308) begin
      failures++; $display("FAIL sw_wb act=%b%b/%h exp=10/00000308", pc_write_enable, reg_write_enable, next_pc_address); end
    exp_instret++;
    tick(); #1;
    checks++; if (instret_count !== 32'(exp_instret)) begin
      failures++; $display("FAIL ls_instret act=%0d exp=%0d", instret_count, exp_instret); end
  endtask

  task automatic test_timeout();
    imem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (imem_req !== 1'b1 || halted !== 1'b0) begin
        failures++; $display("FAIL tmo_wait c=%0d act=%b%b exp=10", c, imem_req, halted); end
      tick();
    end
    #1;
    checks++; if (halted !== 1'b1 || trap_cause !== 3'd4 || imem_req !== 1'b0) begin
      failures++; $display("FAIL tmo_trap act=%b/%0d/%b exp=1/4/0", halted, trap_cause, imem_req); end
  endtask

  task automatic test_reset_recover();
    imem_ready = 1'b1; rst_n = 1'b0; #1;
    checks++; if (halted !== 1'b0 || trap_cause !== 3'd0 || instret_count !== 32'd0 ||
                  imem_req !== 1'b0 || instr_latch_enable !== 1'b0) begin
      failures++; $display("FAIL recover_reset_vals act=%b/%0d/%0d/%b%b exp=0/0/0/00",
                           halted, trap_cause, instret_count, imem_req, instr_latch_enable); end
    tick();
    imem_ready = 1'b0; rst_n = 1'b1; exp_instret = 0; #1;
    checks++; if (imem_req !== 1'b1 || halted !== 1'b0) begin
      failures++; $display("FAIL recover_fetch act=%b%b exp=10", imem_req, halted); end
  endtask

  task automatic test_jalr_misalign();
    set_instr(7'b1100111, 3'b000, 0, 1, 0, 0, 1, 32'h400, 32'h0, 32'h203, 0);
    imem_ready = 1'b1; #1;
    tick();
    imem_ready = 1'b0; #1;
    checks++; if (next_pc_address !== 32'h202) begin
      failures++; $display("FAIL jalr_npc act=%h exp=00000202", next_pc_address); end
    tick();
    for (int c = 0; c < 3; c++) begin
      imem_ready = 1'b1; #1;
      checks++; if (halted !== 1'b1 || trap_cause !== 3'd2 || reg_write_enable !== 1'b0 ||
                    pc_write_enable !== 1'b0 || imem_req !== 1'b0 || instr_latch_enable !== 1'b0) begin
        failures++; $display("FAIL jalr_trap c=%0d act=%b/%0d/%b%b%b%b exp=1/2/0000", c, halted, trap_cause,
                             reg_write_enable, pc_write_enable, imem_req, instr_latch_enable); end
      tick();
    end
    checks++; if (instret_count !== 32'(exp_instret)) begin
      failures++; $display("FAIL jalr_instret act=%0d exp=%0d", instret_count, exp_instret); end
    do_reset();
  endtask

  task automatic test_store_misalign();
    int req_cnt = 0;
    set_instr(7'b0100011, 3'b001, 0, 0, 0, 1, 0, 32'h500, 32'h0, 32'h1001, 0);
    imem_ready = 1'b1; #1;
    tick();
    imem_ready = 1'b0; dmem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1; req_cnt += int'(dmem_req); tick();
    end
    dmem_ready = 1'b0; #1;
    checks++; if (req_cnt != 0) begin failures++; $display("FAIL sh_req_count act=%0d exp=0", req_cnt); end
    checks++; if (halted !== 1'b1 || trap_cause !== 3'd3) begin
      failures++; $display("FAIL sh_trap act=%b/%0d exp=1/3", halted, trap_cause); end
    do_reset();
  endtask

  task automatic test_illegal();
    logic [6:0]  ops [3] = '{7'b0000000, 7'b1100011, 7'b0000011};
    logic [2:0]  f3s [3] = '{3'b000, 3'b010, 3'b010};
    logic        brs [3] = '{1'b0, 1'b1, 1'b0};
    logic        mrs [3] = '{1'b0, 1'b0, 1'b1};
    logic        mws [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] as  [3] = '{32'h0, 32'h0, 32'h1001};
    for (int i = 0; i < 3; i++) begin
      set_instr(ops[i], f3s[i], brs[i], 0, mrs[i], mws[i], 1, 32'h600, 32'h0, as[i], 0);
      imem_ready = 1'b1; #1;
      tick();
      imem_ready = 1'b0;
      tick(); #1;
      checks++; if (halted !== 1'b1 || trap_cause !== 3'd1 || dmem_req !== 1'b0) begin
        failures++; $display("FAIL illegal i=%0d act=%b/%0d/%b exp=1/1/0", i, halted, trap_cause, dmem_req); end
      do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_jal();
    test_load_store();
    test_timeout();
    test_reset_recover();
    test_jalr_misalign();
    test_store_misalign();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
